// File: rtl/uart_tx_prescaled.sv
// Prescaled UART transmitter: start, LSB-first data, optional parity, stop.
// Each bit occupies 'prescale' clocks (clamped to a minimum of 4); outputs are registered.
module uart_tx_prescaled #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            prescale,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state, w_state;
  logic [4:0]            r_cnt, w_cnt;
  logic [4:0]            r_presc, w_presc;
  logic [IW-1:0]         r_idx, w_idx;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic                  r_par_en, w_par_en;
  logic                  r_par, w_par;
  logic                  r_tx, w_tx;
  logic                  r_busy, w_busy;
  logic                  w_last;

  assign w_last = (r_cnt == r_presc - 5'd1);

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_presc  = r_presc;
    w_idx    = r_idx;
    w_shift  = r_shift;
    w_par_en = r_par_en;
    w_par    = r_par;
    w_tx     = r_tx;
    w_busy   = r_busy;
    case (r_state)
      IDLE: begin
        w_cnt  = '0;
        w_idx  = '0;
        w_tx   = 1'b1;
        w_busy = 1'b0;
        if (DATA_VALID && !r_busy) begin
          // Parity is resolved at acceptance so the shift register can be consumed.
          w_state  = START;
          w_shift  = P_DATA;
          w_par_en = PAR_EN;
          w_par    = (^P_DATA) ^ PAR_TYP;
          w_presc  = (prescale < 5'd4) ? 5'd4 : prescale;
          w_tx     = 1'b0;
          w_busy   = 1'b1;
        end
      end
      START: begin
        if (w_last) begin
          w_state = DATA;
          w_cnt   = '0;
          w_idx   = '0;
          w_tx    = r_shift[0];
        end else begin
          w_cnt = r_cnt + 5'd1;
        end
      end
      DATA: begin
        if (w_last) begin
          w_cnt = '0;
          if (r_idx == IW'(DATA_WIDTH - 1)) begin
            w_idx = '0;
            if (r_par_en) begin
              w_state = PARITY;
              w_tx    = r_par;
            end else begin
              w_state = STOP;
              w_tx    = 1'b1;
            end
          end else begin
            w_idx   = r_idx + IW'(1);
            w_shift = r_shift >> 1;
            w_tx    = w_shift[0];
          end
        end else begin
          w_cnt = r_cnt + 5'd1;
        end
      end
      PARITY: begin
        if (w_last) begin
          w_state = STOP;
          w_cnt   = '0;
          w_tx    = 1'b1;
        end else begin
          w_cnt = r_cnt + 5'd1;
        end
      end
      STOP: begin
        if (w_last) begin
          w_state = IDLE;
          w_cnt   = '0;
          w_tx    = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_cnt = r_cnt + 5'd1;
        end
      end
      default: begin
        w_state = IDLE;
        w_cnt   = '0;
        w_idx   = '0;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_presc  <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_presc  <= w_presc;
      r_idx    <= w_idx;
      r_shift  <= w_shift;
      r_par_en <= w_par_en;
      r_par    <= w_par;
      r_tx     <= w_tx;
      r_busy   <= w_busy;
    end
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;
endmodule

// File: tb/tb_uart_tx_prescaled.sv
// Bench for uart_tx_prescaled: fixed frame vectors, random frames against a bit-list
// model, request-while-busy, mid-frame reset and a behavioural receiver on back-to-back frames.
module tb_uart_tx_prescaled;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID, PAR_EN, PAR_TYP;
  logic [4:0]    prescale;
  logic          TX_OUT, busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit cap[$];
  bit exp_seq[$];
  bit line[$];
  logic [DW-1:0] rx_bytes[$];
  int  rx_starts[$];
  int  rx_errs;
  logic idle_tx, idle_busy;

  uart_tx_prescaled #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as a list of line levels, one entry per serial bit.
  function automatic int model_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                                     input int pre);
    int ones = 0;
    exp_seq.delete();
    exp_seq.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      exp_seq.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) exp_seq.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    exp_seq.push_back(1'b1);
    return (pre < 4) ? 4 : pre;
  endfunction

  // Request one frame and record TX_OUT for every busy cycle; stops on the first idle sample.
  task automatic run_frame(input logic [DW-1:0] d, input bit pe, input bit pt, input logic [4:0] pre,
                           input int glitch_at, input bit scramble);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = pre; DATA_VALID = 1'b1;
    cap.delete();
    for (int k = 0; k < 2000; k++) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
      if (scramble) begin
        P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        prescale = 5'($urandom);
      end
      if (k == glitch_at) begin
        DATA_VALID = 1'b1; P_DATA = '0;
      end
      if (!busy) break;
      cap.push_back(TX_OUT);
    end
    idle_tx = TX_OUT; idle_busy = busy;
  endtask

  task automatic compare_model(input string name, input logic [DW-1:0] d, input bit pe,
                               input bit pt, input int pre);
    int p, bad;
    p = model_frame(d, pe, pt, pre);
    check({name, "_len"}, cap.size(), exp_seq.size() * p);
    bad = -1;
    for (int k = 0; k < cap.size(); k++)
      if (bad < 0 && k / p < exp_seq.size() && cap[k] != exp_seq[k / p]) bad = k;
    check({name, "_wave_first_bad"}, bad, -1);
    check({name, "_idle_after"}, {idle_busy, idle_tx}, 2'b01);
  endtask

  // Behavioural receiver: mid-bit sampling of the recorded line.
  task automatic rx_decode(input int p, input bit pe, input bit pt);
    int i, n, ones;
    logic [DW-1:0] b;
    n = DW + 2 + int'(pe);
    rx_bytes.delete(); rx_starts.delete(); rx_errs = 0;
    i = 0;
    while (i + n * p <= line.size()) begin
      if (line[i] == 1'b0 && line[i + p / 2] == 1'b0) begin
        ones = 0;
        for (int j = 0; j < DW; j++) begin
          b[j] = line[i + (1 + j) * p + p / 2];
          ones += int'(b[j]);
        end
        if (pe && line[i + (1 + DW) * p + p / 2] != (pt ? (ones % 2 == 0) : (ones % 2 == 1)))
          rx_errs++;
        if (line[i + (n - 1) * p + p / 2] != 1'b1) rx_errs++;
        rx_bytes.push_back(b);
        rx_starts.push_back(i);
        i += n * p;
      end else begin
        i++;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  d;
    bit          pe, pt;
    logic [4:0]  pre;
    int          p;
    int          nbits;
    logic [10:0] bits;   // transmit order, bit 0 first
    int          busy_len;
  } vec_t;

  vec_t vt[4];

  initial begin
    int nonidle, bad, p;
    logic [DW-1:0] d;
    bit pe, pt;
    logic [4:0] pre;

    vt[0] = '{8'h46, 1'b1, 1'b0, 5'd4, 4, 11, 11'b110_1000_1100, 44};
    vt[1] = '{8'h46, 1'b1, 1'b1, 5'd8, 8, 11, 11'b100_1000_1100, 88};
    vt[2] = '{8'hFF, 1'b0, 1'b0, 5'd4, 4, 10, 11'b011_1111_1110, 40};
    vt[3] = '{8'h00, 1'b1, 1'b0, 5'd2, 4, 11, 11'b100_0000_0000, 44};

    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 5'd4;
    repeat (3) @(negedge CLK);
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", busy, 1'b0);
    P_DATA = 8'h46; PAR_EN = 1'b1; prescale = 5'd4; DATA_VALID = 1'b1;
    @(negedge CLK);
    check("reset_ignores_valid", {busy, TX_OUT}, 2'b01);
    RST = 1'b1;
    @(negedge CLK);
    check("first_accept_after_reset", {busy, TX_OUT}, 2'b10);
    DATA_VALID = 1'b0;
    bad = 1;
    for (int k = 0; k < 500; k++) begin
      @(negedge CLK);
      if (!busy) begin bad = 0; break; end
    end
    check("drain_after_reset", bad, 0);

    for (int i = 0; i < 4; i++) begin
      run_frame(vt[i].d, vt[i].pe, vt[i].pt, vt[i].pre, -1, 1'b1);
      check($sformatf("vec%0d_busy_len", i), cap.size(), vt[i].busy_len);
      bad = -1;
      for (int k = 0; k < cap.size(); k++)
        if (bad < 0 && k / vt[i].p < vt[i].nbits && cap[k] != vt[i].bits[k / vt[i].p]) bad = k;
      check($sformatf("vec%0d_wave_first_bad", i), bad, -1);
      check($sformatf("vec%0d_idle_after", i), {idle_busy, idle_tx}, 2'b01);
    end

    run_frame(8'hA5, 1'b1, 1'b0, 5'd6, 20, 1'b0);
    compare_model("busy_ignore", 8'hA5, 1'b1, 1'b0, 6);
    nonidle = 0;
    repeat (20) begin
      @(negedge CLK);
      if (busy || !TX_OUT) nonidle++;
    end
    check("no_queued_frame", nonidle, 0);

    @(negedge CLK);
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 5'd4; DATA_VALID = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
    end
    check("mid_bit3_level", {busy, TX_OUT}, 2'b10);
    RST = 1'b0;
    @(negedge CLK);
    check("abort_next_cycle", {busy, TX_OUT}, 2'b01);
    RST = 1'b1;
    nonidle = 0;
    repeat (12) begin
      @(negedge CLK);
      if (busy || !TX_OUT) nonidle++;
    end
    check("idle_after_abort", nonidle, 0);

    for (int r = 0; r < 20; r++) begin
      d = DW'($urandom); pe = 1'($urandom); pt = 1'($urandom);
      pre = 5'($urandom_range(0, 31));
      run_frame(d, pe, pt, pre, int'($urandom_range(2, 30)), 1'b1);
      compare_model($sformatf("rand%0d", r), d, pe, pt, int'(pre));
    end

    @(negedge CLK);
    P_DATA = 8'h46; PAR_EN = 1'b1; PAR_TYP = 1'b0; prescale = 5'd4; DATA_VALID = 1'b1;
    line.delete();
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      line.push_back(TX_OUT);
      if (k == 0) P_DATA = 8'h3C;
      if (k == 50) DATA_VALID = 1'b0;
    end
    rx_decode(4, 1'b1, 1'b0);
    check("loop_count", rx_bytes.size(), 2);
    if (rx_bytes.size() == 2) begin
      check("loop_byte0", rx_bytes[0], 8'h46);
      check("loop_byte1", rx_bytes[1], 8'h3C);
      check("loop_start0", rx_starts[0], 0);
      check("loop_gap", rx_starts[1], 45);
    end
    check("loop_frame_errs", rx_errs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_prescaled.md
UART_TX_PRESCALED -- requirements
Module: uart_tx_prescaled

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port P_DATA, input, DATA_WIDTH bits: parallel byte to transmit.
REQ-005 SHALL have port DATA_VALID, input, 1 bit: P_DATA is valid, and a frame is requested.
REQ-006 SHALL have port PAR_EN, input, 1 bit: 1 inserts a parity bit.
REQ-007 SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-008 SHALL have port prescale, input, 5 bits: CLK cycles per serial bit.
REQ-009 SHALL have port TX_OUT, output, 1 bit: serial line; idle level is high.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress; new requests are ignored.

Function
REQ-011 SHALL have FSM states IDLE, START, DATA, PARITY and STOP, with every output registered.
REQ-012 SHALL accept a request on the rising edge where DATA_VALID=1, busy=0 and the state is IDLE.
REQ-013 SHALL latch P_DATA, PAR_EN, PAR_TYP and prescale at acceptance; later input changes SHALL NOT affect the frame.
REQ-014 SHALL, in the cycle after acceptance, drive TX_OUT=0, set busy=1 and enter START.
REQ-015 SHALL treat a latched prescale value below 4 as 4; legal values are 4..31.
REQ-016 SHALL hold each bit (start, data, parity, stop) on TX_OUT for exactly the latched-prescale number of cycles, using a bit-cycle counter.
REQ-017 SHALL, in DATA, send the bits LSB first, counting DATA_WIDTH bits with a bit index.
REQ-018 SHALL, after DATA, go to PARITY when PAR_EN=1, otherwise go straight to STOP.
REQ-019 SHALL set the parity bit to XOR(data) when PAR_TYP=0 (even) and to ~XOR(data) when PAR_TYP=1 (odd).
REQ-020 SHALL drive TX_OUT=1 in STOP.
REQ-021 SHALL make the frame length N*prescale cycles, where N=DATA_WIDTH+3 with parity or DATA_WIDTH+2 without.
REQ-022 SHALL, on the edge ending the last STOP cycle, return to IDLE with busy=0 and TX_OUT=1.
REQ-023 SHALL make the earliest next acceptance the following edge, so back-to-back frames are separated by at least one extra idle-high cycle.
REQ-024 SHALL ignore DATA_VALID while busy=1: no queueing and no corruption of the current frame.
REQ-025 SHALL let DATA_VALID held high continuously start a new frame after each minimum idle gap.
REQ-026 SHALL NOT wrap the bit-cycle counter or bit index outside their range; both SHALL clear at every bit and frame boundary.

Reset
REQ-027 SHALL, on a rising edge with RST=0, set TX_OUT=1, busy=0, state=IDLE and clear all counters and data/config registers.
REQ-028 SHALL, on reset mid-frame, abort the frame immediately, with the line high on the next cycle; no partial frame SHALL resume.
REQ-029 SHALL make the first acceptance after reset possible on the first edge with RST=1, DATA_VALID=1.

Verification
REQ-030 SHALL cover: P_DATA=0x46, PAR_EN=1, PAR_TYP=0, prescale=4 -> TX_OUT bits 0,0,1,1,0,0,0,1,0,1,1, each 4 cycles; busy high for 44 cycles.
REQ-031 SHALL cover: the same data with prescale=8 and PAR_TYP=1 -> parity bit 0; busy high for 88 cycles.
REQ-032 SHALL cover: P_DATA=0xFF, PAR_EN=0, prescale=4 -> bits 0, eight 1s, then 1; 40 cycles; no parity slot.
REQ-033 SHALL cover: DATA_VALID pulsed with 0x00 during a 0xA5 frame -> the 0xA5 waveform is unchanged; 0x00 is never sent.
REQ-034 SHALL cover: RST=0 in the middle of data bit 3 -> TX_OUT=1 and busy=0 next cycle; the line stays idle until a new DATA_VALID.
REQ-035 SHALL cover loopback: TX_OUT wired to UART_RX RX_IN, matching PAR_EN/PAR_TYP/prescale, two back-to-back bytes 0x46 and 0x3C -> RX data_valid pulses twice, with P_DATA=0x46 then 0x3C.
